// File: rtl/mul_normaliser_seq.sv
// Sequential normaliser for a raw floating-point product: shifts the mantissa
// until the hidden bit is set, tracking exponent, shift count and exception flags.
module mul_normaliser_seq #(
    parameter int EW = 8,
    parameter int MW = 48,
    parameter int CW = $clog2(MW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_e,
    input  logic [MW-1:0] in_m,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_m,
    output logic [CW-1:0] shift_cnt,
    output logic          zero,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [EW-1:0] E_ONE   = EW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_nx;
    logic [EW-1:0] e_q, e_nx;
    logic [MW-1:0] m_q, m_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic          zero_q, zero_nx;
    logic          ovf_q, ovf_nx;
    logic          unf_q, unf_nx;
    logic          rdy_q, rdy_nx;

    // Saturating exponent increment; MSB of the result is the overflow flag.
    function automatic logic [EW:0] sat_inc(input logic [EW-1:0] e);
        if (&e) return {1'b1, e};
        else    return {1'b0, e + E_ONE};
    endfunction

    always_comb begin
        state_nx = state;
        e_nx     = e_q;
        m_nx     = m_q;
        cnt_nx   = cnt_q;
        zero_nx  = zero_q;
        ovf_nx   = ovf_q;
        unf_nx   = unf_q;
        case (state)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    e_nx     = in_e;
                    m_nx     = in_m;
                    cnt_nx   = '0;
                    zero_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    zero_nx  = 1'b1;
                    e_nx     = '0;
                    state_nx = DONE;
                end else if (m_q[MW-1]) begin
                    // Right shift keeps the discarded bit as a sticky LSB.
                    m_nx           = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                    {ovf_nx, e_nx} = sat_inc(e_q);
                    state_nx       = DONE;
                end else if (m_q[MW-2]) begin
                    state_nx = DONE;
                end else if (e_q == '0) begin
                    unf_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    m_nx   = m_q << 1;
                    e_nx   = e_q - E_ONE;
                    cnt_nx = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        rdy_nx = (state_nx == IDLE);
    end

    // Ready is registered so it stays low on the reset edge itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            e_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            e_q    <= e_nx;
            m_q    <= m_nx;
            cnt_q  <= cnt_nx;
            zero_q <= zero_nx;
            ovf_q  <= ovf_nx;
            unf_q  <= unf_nx;
            rdy_q  <= rdy_nx;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state == DONE);
    assign out_e     = e_q;
    assign out_m     = m_q;
    assign shift_cnt = cnt_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
